// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/discard FSM and IF/ID register.
// A redirect that arrives mid-fetch parks its target until the stale word returns.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcSrcE,
    input  logic [31:0] pcTargetE,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemReady,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcPlus4D,
    output logic        validD,
    output logic        fetchBusy
);

    typedef enum logic {
        RUN,
        DISCARD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_f;
    logic [31:0] pc_next;
    logic [31:0] redir_pc;
    logic [31:0] redir_next;
    logic        delivered;

    assign imemReq   = ~rst;
    assign imemAddr  = pc_f;
    assign fetchBusy = (imemReq & ~imemReady) | (~rst & (state == DISCARD));

    always_comb begin
        state_next = state;
        pc_next    = pc_f;
        redir_next = redir_pc;
        delivered  = 1'b0;
        case (state)
            RUN: begin
                if (pcSrcE) begin
                    if (imemReady) begin
                        pc_next = pcTargetE;
                    end else begin
                        redir_next = pcTargetE;
                        state_next = DISCARD;
                    end
                end else if (imemReady && !stallF) begin
                    pc_next   = pc_f + 32'd4;
                    delivered = 1'b1;
                end
            end
            DISCARD: begin
                // the returning word belongs to the abandoned path
                if (imemReady) begin
                    pc_next    = pcSrcE ? pcTargetE : redir_pc;
                    state_next = RUN;
                end else if (pcSrcE) begin
                    redir_next = pcTargetE;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc_f     <= RESET_PC;
            redir_pc <= 32'h0;
        end else begin
            state    <= state_next;
            pc_f     <= pc_next;
            redir_pc <= redir_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instrD   <= NOP_INSTR;
            pcD      <= 32'h0;
            pcPlus4D <= 32'h0;
            validD   <= 1'b0;
        end else if (flushD) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (!stallD) begin
            if (delivered) begin
                instrD   <= imemRdata;
                pcD      <= pc_f;
                pcPlus4D <= pc_f + 32'd4;
                validD   <= 1'b1;
            end else begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns the address as data.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcSrcE;
    logic [31:0] pcTargetE;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemReady;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        validD;
    logic        fetchBusy;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushD    (flushD),
        .pcSrcE    (pcSrcE),
        .pcTargetE (pcTargetE),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemRdata (imemRdata),
        .imemReady (imemReady),
        .instrD    (instrD),
        .pcD       (pcD),
        .pcPlus4D  (pcPlus4D),
        .validD    (validD),
        .fetchBusy (fetchBusy)
    );

    always #5 clk = ~clk;

    assign imemRdata = imemAddr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        pcSrcE    = 1'b0;
        pcTargetE = 32'h0;
        imemReady = 1'b1;
        tick();
        tick();
        chk("rst_req", {31'h0, imemReq}, 32'h0);
        chk("rst_busy", {31'h0, fetchBusy}, 32'h0);
        chk("rst_pc", imemAddr, 32'h0);
        chk("rst_instr", instrD, 32'h13);
        chk("rst_valid", {31'h0, validD}, 32'h0);
        chk("rst_pcd", pcD, 32'h0);

        // sequential fetch
        rst = 1'b0;
        #1;
        chk("run_req", {31'h0, imemReq}, 32'h1);
        tick();
        chk("seq1_pc", imemAddr, 32'h4);
        chk("seq1_instr", instrD, 32'h0);
        chk("seq1_valid", {31'h0, validD}, 32'h1);
        chk("seq1_p4", pcPlus4D, 32'h4);
        tick();
        chk("seq2_pc", imemAddr, 32'h8);
        chk("seq2_instr", instrD, 32'h4);
        chk("seq2_pcd", pcD, 32'h4);

        // memory wait at 0x8
        imemReady = 1'b0;
        #1;
        chk("wait_busy0", {31'h0, fetchBusy}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", imemAddr, 32'h8);
            chk("wait_busy", {31'h0, fetchBusy}, 32'h1);
            chk("wait_valid", {31'h0, validD}, 32'h0);
        end
        imemReady = 1'b1;
        tick();
        chk("wait_instr", instrD, 32'h8);
        chk("wait_pcd", pcD, 32'h8);
        chk("wait_valid1", {31'h0, validD}, 32'h1);
        chk("wait_pc", imemAddr, 32'hC);

        // redirect with ready: word dropped
        pcSrcE    = 1'b1;
        pcTargetE = 32'h20;
        tick();
        chk("redir_pc", imemAddr, 32'h20);
        chk("redir_valid", {31'h0, validD}, 32'h0);
        chk("redir_busy", {31'h0, fetchBusy}, 32'h0);

        // redirect while fetch outstanding
        pcTargetE = 32'h100;
        imemReady = 1'b0;
        #1;
        chk("disc_busy0", {31'h0, fetchBusy}, 32'h1);
        tick();
        pcSrcE = 1'b0;
        #1;
        chk("disc_addr1", imemAddr, 32'h20);
        chk("disc_busy1", {31'h0, fetchBusy}, 32'h1);
        chk("disc_valid1", {31'h0, validD}, 32'h0);
        tick();
        chk("disc_addr2", imemAddr, 32'h20);
        chk("disc_busy2", {31'h0, fetchBusy}, 32'h1);
        imemReady = 1'b1;
        #1;
        chk("disc_busy3", {31'h0, fetchBusy}, 32'h1);
        tick();
        chk("disc_pc", imemAddr, 32'h100);
        chk("disc_valid", {31'h0, validD}, 32'h0);
        chk("disc_busy4", {31'h0, fetchBusy}, 32'h0);

        // stall at 0x40
        pcSrcE    = 1'b1;
        pcTargetE = 32'h3C;
        tick();
        pcSrcE = 1'b0;
        tick();
        chk("pre_stall_instr", instrD, 32'h3C);
        chk("pre_stall_pc", imemAddr, 32'h40);
        stallF = 1'b1;
        stallD = 1'b1;
        tick();
        chk("stall_pc", imemAddr, 32'h40);
        chk("stall_instr", instrD, 32'h3C);
        chk("stall_pcd", pcD, 32'h3C);
        chk("stall_valid", {31'h0, validD}, 32'h1);
        stallF = 1'b0;
        stallD = 1'b0;
        tick();
        chk("post_stall_instr", instrD, 32'h40);
        chk("post_stall_pcd", pcD, 32'h40);
        chk("post_stall_pc", imemAddr, 32'h44);

        // latest redirect wins in DISCARD
        imemReady = 1'b0;
        pcSrcE    = 1'b1;
        pcTargetE = 32'h200;
        tick();
        pcTargetE = 32'h300;
        tick();
        pcSrcE    = 1'b0;
        imemReady = 1'b1;
        tick();
        chk("latest_pc", imemAddr, 32'h300);
        chk("latest_valid", {31'h0, validD}, 32'h0);

        // flush beats stall
        tick();
        chk("pre_flush_instr", instrD, 32'h300);
        flushD = 1'b1;
        stallD = 1'b1;
        tick();
        chk("flush_instr", instrD, 32'h13);
        chk("flush_valid", {31'h0, validD}, 32'h0);
        chk("flush_pcd", pcD, 32'h300);
        flushD = 1'b0;
        stallD = 1'b0;

        // PC wrap
        pcSrcE    = 1'b1;
        pcTargetE = 32'hFFFF_FFFC;
        tick();
        pcSrcE = 1'b0;
        chk("wrap_pre", imemAddr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", imemAddr, 32'h0);
        chk("wrap_instr", instrD, 32'hFFFF_FFFC);
        chk("wrap_p4", pcPlus4D, 32'h0);

        // reset while discarding
        imemReady = 1'b0;
        pcSrcE    = 1'b1;
        pcTargetE = 32'h500;
        tick();
        pcSrcE = 1'b0;
        rst    = 1'b1;
        #1;
        chk("mrst_req", {31'h0, imemReq}, 32'h0);
        chk("mrst_busy", {31'h0, fetchBusy}, 32'h0);
        tick();
        rst       = 1'b0;
        imemReady = 1'b1;
        #1;
        chk("mrst_busy2", {31'h0, fetchBusy}, 32'h0);
        chk("mrst_addr", imemAddr, 32'h0);
        tick();
        chk("mrst_pc", imemAddr, 32'h4);
        chk("mrst_instr", instrD, 32'h0);
        chk("mrst_valid", {31'h0, validD}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction word placed in D for bubbles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stallF, input, 1, hold the PC (from the hazard unit).
REQ-006 SHALL have port stallD, input, 1, hold the IF/ID register.
REQ-007 SHALL have port flushD, input, 1, load a bubble into the IF/ID register.
REQ-008 SHALL have port pcSrcE, input, 1, redirect is taken, resolved in E.
REQ-009 SHALL have port pcTargetE, input, 32, redirect target.
REQ-010 SHALL have port imemReq, output, 1, fetch request.
REQ-011 SHALL have port imemAddr, output, 32, fetch address, equal to pcF.
REQ-012 SHALL have port imemRdata, input, 32, instruction word, valid when imemReady=1.
REQ-013 SHALL have port imemReady, input, 1, fetch completes this cycle.
REQ-014 SHALL have port instrD, output, 32, the instruction in D.
REQ-015 SHALL have port pcD, output, 32, the PC of instrD.
REQ-016 SHALL have port pcPlus4D, output, 32, pcD+4.
REQ-017 SHALL have port validD, output, 1, instrD is a real instruction.
REQ-018 SHALL have port fetchBusy, output, 1, a fetch is outstanding or a fetch is being discarded.

Function
REQ-019 SHALL hold a 32-bit pcF register; imemAddr=pcF; imemReq=1 in every cycle except reset cycles.
REQ-020 SHALL keep imemAddr stable while imemReq=1 and imemReady=0.
REQ-021 SHALL implement FSM states RUN and DISCARD, plus a 32-bit redirPc register.
REQ-022 RUN, pcSrcE=1, imemReady=1: pcF<=pcTargetE; the fetched word is dropped; stay in RUN.
REQ-023 RUN, pcSrcE=1, imemReady=0: redirPc<=pcTargetE; pcF holds; go to DISCARD.
REQ-024 RUN, pcSrcE=0, imemReady=1, stallF=0: pcF<=pcF+4, with 32-bit wrap-around (32'hFFFF_FFFC -> 0).
REQ-025 RUN, pcSrcE=0, with imemReady=0 or stallF=1: pcF holds; a fetch dropped because of stallF is re-fetched.
REQ-026 DISCARD, imemReady=0: pcF holds; a new pcSrcE=1 overwrites redirPc (latest redirect wins).
REQ-027 DISCARD, imemReady=1: pcF<=(pcSrcE ? pcTargetE : redirPc); the word is dropped; go to RUN.
REQ-028 pcSrcE SHALL override stallF in every state.
REQ-029 fetchBusy SHALL be (imemReq & ~imemReady) | (state==DISCARD).
REQ-030 A fetch is delivered when state==RUN, imemReady=1, pcSrcE=0 and stallF=0.
REQ-031 IF/ID priority SHALL be: flushD first, then stallD (hold all D outputs), then load.
REQ-032 Load with a delivered fetch: instrD<=imemRdata, pcD<=pcF, pcPlus4D<=pcF+4, validD<=1.
REQ-033 Load with no delivered fetch, or on flushD: instrD<=NOP_INSTR, validD<=0, pcD and pcPlus4D hold.
REQ-034 Fetch-to-D latency SHALL be 1 cycle: a word accepted at edge N is on instrD after edge N.

Reset
REQ-035 On rst=1 at a clock edge: pcF<=RESET_PC, state<=RUN, redirPc<=0, instrD<=NOP_INSTR, pcD<=0, pcPlus4D<=0, validD<=0.
REQ-036 During a reset cycle: imemReq=0 and fetchBusy=0.
REQ-037 Reset mid-operation, including in DISCARD, SHALL abandon the outstanding fetch and any pending redirect.

Verification
REQ-038 Reset release, imemReady=1 constantly, imem word = address -> pcF = 0,4,8...; instrD lags by 1 cycle; validD=1 from cycle 2.
REQ-039 imemReady=0 for 3 cycles at pcF=8 -> imemAddr=8 held, fetchBusy=1, validD=0 in D; then instrD=word@8, pcD=8.
REQ-040 pcSrcE=1, pcTargetE=0x100, imemReady=0 at pcF=0x20; ready 2 cycles later -> word@0x20 dropped (validD=0); pcF=0x100; fetchBusy=1 throughout.
REQ-041 stallF=stallD=1 for 1 cycle at pcF=0x40 -> pcF and D hold; next cycle 0x40 re-fetched; no instruction lost or duplicated in D.
REQ-042 flushD=1 together with stallD=1 -> instrD=0x13, validD=0 (flush wins); pcF=0xFFFF_FFFC with ready -> pcF wraps to 0.
